io_bus_pdu: RTL and testbench



---
 rtl/io_bus_pkg.sv | 41 ++++
 rtl/btn_debounce.sv | 45 ++++
 rtl/io_bus_pdu.sv | 118 +++++++++++
 tb/tb_io_bus_pdu.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bus_pkg.sv
// Shared definitions for the IO bus responder: register addresses, debug display
// source encodings and the hex-to-seven-segment decoder.
package io_bus_pkg;

  localparam logic [7:0] ADDR_LED     = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_IN_DATA = 8'h08;
  localparam logic [7:0] ADDR_SEG     = 8'h0C;

  typedef enum logic [1:0] {
    DbgPc  = 2'd0,
    DbgRf  = 2'd1,
    DbgMem = 2'd2,
    DbgSeg = 2'd3
  } dbg_sel_e;

  // Segment order {g,f,e,d,c,b,a}, active-low.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, debounce counter, stable level and a
// one-cycle press pulse on each accepted rising edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             meta_q, sync_q, stable_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  // The counter only advances while the synced level disagrees with the accepted one,
  // so any bounce back to the old level restarts the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q  <= btn;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q    <= '0;
        stable_q <= sync_q;
        press_q  <= sync_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/io_bus_pdu.sv
// Memory-mapped IO responder: LED and seven-segment registers, debounced switch sampling
// with a valid/ack handshake, and a multiplexed display scan. Option: DBG_VIEW_EN.
module io_bus_pdu
  import io_bus_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000,
  parameter int unsigned SCAN_DIV     = 100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  io_addr,
  input  logic [31:0] io_dout,
  input  logic        io_we,
  output logic [31:0] io_din,
  input  logic        btn,
  input  logic [15:0] sw,
  output logic [7:0]  led,
  output logic [7:0]  an,
  output logic [6:0]  seg
`ifdef DBG_VIEW_EN
  ,
  input  logic        dbg_mode,
  input  logic [1:0]  dbg_sel,
  output logic [7:0]  m_rf_addr,
  input  logic [31:0] rf_data,
  input  logic [31:0] m_data,
  input  logic [31:0] pc
`endif
);

  localparam int unsigned SCAN_W = $clog2(SCAN_DIV);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [15:0]       sw_meta_q, sw_sync_q, sw_latched_q;
  logic [7:0]        led_q;
  logic [31:0]       seg_data_q;
  logic              in_valid_q;
  logic [SCAN_W-1:0] scan_q;
  logic [2:0]        digit_q;
  logic              press, ack;
  logic [31:0]       disp;

  btn_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_btn_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn  (btn),
    .press(press)
  );

  assign ack = io_we && (io_addr == ADDR_STATUS);

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q    <= '0;
      sw_sync_q    <= '0;
      sw_latched_q <= '0;
      led_q        <= '0;
      seg_data_q   <= '0;
      in_valid_q   <= 1'b0;
      scan_q       <= '0;
      digit_q      <= '0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (io_we && (io_addr == ADDR_LED)) led_q <= io_dout[7:0];
      if (io_we && (io_addr == ADDR_SEG)) seg_data_q <= io_dout;
      // A fresh sample beats a simultaneous ack so it is never lost.
      if (press) begin
        in_valid_q   <= 1'b1;
        sw_latched_q <= sw_sync_q;
      end else if (ack) begin
        in_valid_q <= 1'b0;
      end
      if (scan_q == SCAN_LAST) begin
        scan_q  <= '0;
        digit_q <= digit_q + 3'd1;
      end else begin
        scan_q <= scan_q + SCAN_W'(1);
      end
    end
  end

  always_comb begin
    io_din = '0;
    case (io_addr)
      ADDR_LED:     io_din = {24'b0, led_q};
      ADDR_STATUS:  io_din = {31'b0, in_valid_q};
      ADDR_IN_DATA: io_din = {16'b0, sw_latched_q};
      ADDR_SEG:     io_din = seg_data_q;
      default:      io_din = '0;
    endcase
  end

  always_comb begin
    disp = seg_data_q;
`ifdef DBG_VIEW_EN
    if (dbg_mode) begin
      case (dbg_sel_e'(dbg_sel))
        DbgPc:   disp = pc;
        DbgRf:   disp = rf_data;
        DbgMem:  disp = m_data;
        default: disp = seg_data_q;
      endcase
    end
`endif
  end

`ifdef DBG_VIEW_EN
  assign m_rf_addr = sw_sync_q[7:0];
`endif

  assign led = led_q;
  assign an  = ~(8'b1 << digit_q);
  assign seg = hex_to_seg(disp[{digit_q, 2'b00} +: 4]);

endmodule

// File: tb/tb_io_bus_pdu.sv
// Bench for io_bus_pdu: a history-based model checked every cycle plus directed
// literal checks. Exercises DBG_VIEW_EN paths when that macro is defined.
`timescale 1ns/1ps
module tb_io_bus_pdu;

  localparam int DEB  = 4;
  localparam int SCAN = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  io_addr = 8'h00;
  logic [31:0] io_dout = 32'h0;
  logic        io_we = 1'b0;
  logic [31:0] io_din;
  logic        btn = 1'b0;
  logic [15:0] sw = 16'h0;
  logic [7:0]  led, an;
  logic [6:0]  seg;
`ifdef DBG_VIEW_EN
  logic        dbg_mode = 1'b0;
  logic [1:0]  dbg_sel = 2'd0;
  logic [7:0]  m_rf_addr;
  logic [31:0] rf_data = 32'h0;
  logic [31:0] m_data = 32'h0;
  logic [31:0] pc = 32'h0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  io_bus_pdu #(
    .DEBOUNCE_CYC(DEB),
    .SCAN_DIV    (SCAN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .io_addr  (io_addr),
    .io_dout  (io_dout),
    .io_we    (io_we),
    .io_din   (io_din),
    .btn      (btn),
    .sw       (sw),
    .led      (led),
    .an       (an),
    .seg      (seg)
`ifdef DBG_VIEW_EN
    ,
    .dbg_mode (dbg_mode),
    .dbg_sel  (dbg_sel),
    .m_rf_addr(m_rf_addr),
    .rf_data  (rf_data),
    .m_data   (m_data),
    .pc       (pc)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  // Model state: raw inputs seen at each edge; the synchronised value used at an edge
  // is the raw value from two edges earlier.
  logic [7:0]  m_led = 8'h0;
  logic [31:0] m_seg = 32'h0;
  bit          m_valid = 1'b0;
  logic [15:0] m_latched = 16'h0;
  bit          m_stable = 1'b0;
  bit          m_pend = 1'b0;
  int          m_cycles = 0;
  bit          m_init = 1'b0;
  bit          hist_btn[$];
  logic [15:0] hist_sw[$];

  function automatic int m_digit();
    return (m_cycles / SCAN) % 8;
  endfunction

  function automatic logic [31:0] m_disp();
`ifdef DBG_VIEW_EN
    if (dbg_mode) begin
      case (dbg_sel)
        2'd0:    return pc;
        2'd1:    return rf_data;
        2'd2:    return m_data;
        default: return m_seg;
      endcase
    end
`endif
    return m_seg;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] a);
    case (a)
      8'h00:   return {24'h0, m_led};
      8'h04:   return {31'h0, m_valid};
      8'h08:   return {16'h0, m_latched};
      8'h0C:   return m_seg;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    bit all_diff;
    if (rst) begin
      m_led = 8'h0; m_seg = 32'h0; m_valid = 1'b0; m_latched = 16'h0;
      m_stable = 1'b0; m_pend = 1'b0; m_cycles = 0;
      if (hist_btn.size() > 0) begin
        hist_btn[hist_btn.size()-1] = 1'b0;
        hist_sw[hist_sw.size()-1]   = 16'h0;
      end
      hist_btn.push_back(1'b0);
      hist_sw.push_back(16'h0);
    end else begin
      if (m_pend) begin
        m_valid   = 1'b1;
        m_latched = hist_sw[hist_sw.size()-2];
      end else if (io_we && io_addr == 8'h04) begin
        m_valid = 1'b0;
      end
      if (io_we && io_addr == 8'h00) m_led = io_dout[7:0];
      if (io_we && io_addr == 8'h0C) m_seg = io_dout;
      m_pend = 1'b0;
      // Accept a new level once DEB consecutive synced samples disagree with it.
      if (hist_btn.size() >= DEB + 1) begin
        all_diff = 1'b1;
        for (int i = 2; i <= DEB + 1; i++)
          if (hist_btn[hist_btn.size()-i] == m_stable) all_diff = 1'b0;
        if (all_diff) begin
          m_stable = !m_stable;
          m_pend   = m_stable;
        end
      end
      hist_btn.push_back(btn);
      hist_sw.push_back(sw);
      m_cycles++;
    end
    m_init = 1'b1;
  end

  always @(negedge clk) begin
    logic [7:0]  exp_an;
    logic [31:0] d;
    if (m_init) begin
      exp_an = ~(8'h01 << m_digit());
      d = m_disp();
      chk("led", {24'h0, led}, {24'h0, m_led});
      chk("an", {24'h0, an}, {24'h0, exp_an});
      chk("seg", {25'h0, seg}, {25'h0, exp_seg(d[4*m_digit() +: 4])});
      chk("io_din", io_din, m_read(io_addr));
`ifdef DBG_VIEW_EN
      chk("m_rf_addr", {24'h0, m_rf_addr}, {24'h0, hist_sw[hist_sw.size()-2][7:0]});
`endif
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
    io_addr = a;
    @(negedge clk);
    chk(name, io_din, exp);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_digit(input int d);
    for (int i = 0; i < 40; i++) begin
      if (m_digit() == d) break;
      tick(1);
    end
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_led", {24'h0, led}, 32'h0);
    chk("rst_an", {24'h0, an}, 32'hFE);
    chk("rst_seg", {25'h0, seg}, 32'h40);
    tick(1);
    read_chk("rst_status", 8'h04, 32'h0);

    io_addr = 8'h00; io_dout = 32'hA5; io_we = 1'b1;
    tick(1);
    io_we = 1'b0; io_dout = 32'h0;
    @(negedge clk);
    chk("led_write", {24'h0, led}, 32'hA5);
    tick(1);
    read_chk("led_read", 8'h00, 32'h0000_00A5);

    sw = 16'h1234; btn = 1'b1;
    tick(10);
    read_chk("hs_status", 8'h04, 32'h1);
    read_chk("hs_data", 8'h08, 32'h0000_1234);
    io_addr = 8'h04; io_we = 1'b1;
    tick(1);
    io_we = 1'b0;
    read_chk("ack_status", 8'h04, 32'h0);
    btn = 1'b0;
    tick(10);

    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(2);
    end
    btn = 1'b0;
    tick(6);
    read_chk("bounce_status", 8'h04, 32'h0);

    sw = 16'hBEEF; btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (m_pend) break;
    end
    chk("press_seen", {31'h0, m_pend}, 32'h1);
    io_addr = 8'h04; io_we = 1'b1;
    tick(1);
    io_we = 1'b0;
    read_chk("collide_status", 8'h04, 32'h1);
    read_chk("collide_data", 8'h08, 32'h0000_BEEF);

    btn = 1'b0;
    tick(8);
    sw = 16'h00FF; btn = 1'b1;
    tick(10);
    read_chk("overwrite_status", 8'h04, 32'h1);
    read_chk("overwrite_data", 8'h08, 32'h0000_00FF);
    btn = 1'b0;
    tick(8);

    io_addr = 8'h0C; io_dout = 32'h89AB_CDEF; io_we = 1'b1;
    tick(1);
    io_we = 1'b0; io_dout = 32'h0;
    read_chk("seg_read", 8'h0C, 32'h89AB_CDEF);
    wait_digit(0);
    @(negedge clk);
    chk("scan_d0_an", {24'h0, an}, 32'hFE);
    chk("scan_d0_seg", {25'h0, seg}, 32'h0E);
    tick(1);
    wait_digit(7);
    @(negedge clk);
    chk("scan_d7_an", {24'h0, an}, 32'h7F);
    chk("scan_d7_seg", {25'h0, seg}, 32'h00);
    tick(1);

    btn = 1'b1;
    tick(3);
    rst = 1'b1; io_addr = 8'h00; io_dout = 32'hFF; io_we = 1'b1;
    tick(2);
    rst = 1'b0; io_we = 1'b0; io_dout = 32'h0;
    @(negedge clk);
    chk("rst_write_dropped", {24'h0, led}, 32'h0);
    tick(1);
    read_chk("rst_clears_valid", 8'h04, 32'h0);
    tick(10);
    read_chk("post_rst_status", 8'h04, 32'h1);
    read_chk("post_rst_data", 8'h08, 32'h0000_00FF);
    btn = 1'b0;

`ifdef DBG_VIEW_EN
    dbg_mode = 1'b1; dbg_sel = 2'd0; pc = 32'h0000_3000; sw = 16'h005A;
    rf_data = 32'h0000_0007;
    tick(4);
    wait_digit(3);
    @(negedge clk);
    chk("dbg_pc_d3", {25'h0, seg}, 32'h30);
    tick(1);
    wait_digit(0);
    @(negedge clk);
    chk("dbg_pc_d0", {25'h0, seg}, 32'h40);
    chk("dbg_rf_addr", {24'h0, m_rf_addr}, 32'h5A);
    tick(1);
    dbg_sel = 2'd1;
    tick(16);
    dbg_mode = 1'b0;
`endif
    tick(4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
